// File: rtl/result_packetizer.sv
// Transmit framer: captures a result word and sends header, MSB-first data bytes
// and an XOR checksum over a byte strobe interface, pacing bytes by a fixed gap.
module result_packetizer #(
    parameter int          DATA_W  = 64,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int          GAP_CYC = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_res_valid,
    input  logic [DATA_W-1:0] i_res_data,
    input  logic              i_tx_ready,
    output logic              o_com_txvalid,
    output logic [7:0]        o_com_txdata,
    output logic              o_busy,
    output logic [7:0]        o_drop_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              r_ret;
    logic [DATA_W-1:0]   r_shadow;
    logic [7:0]          r_csum;
    logic [IDX_W-1:0]    r_idx;
    logic [GAP_W-1:0]    r_gap;
    logic                r_txvalid;
    logic [7:0]          r_txdata;
    logic                r_busy;
    logic [7:0]          r_drop;

    state_t              w_state_nxt;
    logic                w_issue;
    logic                w_capture;
    logic                w_drop;
    logic [7:0]          w_byte;
    logic [7:0]          w_data_byte;

    assign w_data_byte = r_shadow[{r_idx, 3'b000} +: 8];

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_byte      = HEADER;
        w_drop      = i_res_valid && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_res_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (i_tx_ready) begin
                    w_issue     = 1'b1;
                    w_byte      = HEADER;
                    w_state_nxt = S_GAP;
                end
            end
            S_DATA: begin
                if (i_tx_ready) begin
                    w_issue     = 1'b1;
                    w_byte      = w_data_byte;
                    w_state_nxt = S_GAP;
                end
            end
            S_CSUM: begin
                if (i_tx_ready) begin
                    w_issue     = 1'b1;
                    w_byte      = r_csum;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = r_ret;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_ret     <= S_IDLE;
            r_shadow  <= '0;
            r_csum    <= 8'h00;
            r_idx     <= '0;
            r_gap     <= '0;
            r_txvalid <= 1'b0;
            r_txdata  <= 8'h00;
            r_busy    <= 1'b0;
            r_drop    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_txvalid <= w_issue;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_capture) begin
                r_shadow <= i_res_data;
                r_csum   <= HEADER;
                r_idx    <= IDX_W'(NB - 1);
            end
            if (w_issue) begin
                r_txdata <= w_byte;
                r_gap    <= GAP_W'(GAP_CYC - 1);
                case (r_state)
                    S_HDR:  r_ret <= S_DATA;
                    S_DATA: begin
                        r_csum <= r_csum ^ w_data_byte;
                        r_idx  <= r_idx - 1'b1;
                        r_ret  <= (r_idx == '0) ? S_CSUM : S_DATA;
                    end
                    default: r_ret <= S_IDLE;
                endcase
            end else if (r_state == S_GAP && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            // Saturate rather than wrap so a flood of results stays visible.
            if (w_drop && r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'h01;
            end
        end
    end

    assign o_com_txvalid = r_txvalid;
    assign o_com_txdata  = r_txdata;
    assign o_busy        = r_busy;
    assign o_drop_cnt    = r_drop;

endmodule

// File: tb/tb_result_packetizer.sv
// Scoreboard bench for result_packetizer: expected bytes are queued at stimulus
// time and a negedge monitor pops and compares on every byte strobe.
module tb_result_packetizer;
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] res_data = '0;
    logic        tx_ready = 1'b1;
    logic        com_txvalid;
    logic [7:0]  com_txdata;
    logic        busy;
    logic [7:0]  drop_cnt;

    result_packetizer #(.DATA_W(64), .HEADER(8'hA5), .GAP_CYC(GAP)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_res_valid   (res_valid),
        .i_res_data    (res_data),
        .i_tx_ready    (tx_ready),
        .o_com_txvalid (com_txvalid),
        .o_com_txdata  (com_txdata),
        .o_busy        (busy),
        .o_drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int stb_t[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rstn && com_txvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%02h required=none", com_txdata);
            end else begin
                e = exp_q.pop_front();
                check("packet_byte", {56'h0, com_txdata}, {56'h0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [63:0] d);
        res_data  = d;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic push_pkt(input logic [63:0] d, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
        exp_q.push_back(cs);
    endtask

    task automatic wait_strobes(input int n);
        int k = 0;
        int budget = 0;
        while (k < n && budget < 3000) begin
            tick();
            budget++;
            if (com_txvalid) begin
                k++;
                stb_t.push_back(cyc);
            end
        end
        if (k < n) check("strobe_timeout", k, n);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;

        #1;
        check("reset_txvalid", com_txvalid, 0);
        check("reset_txdata", com_txdata, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_drop", drop_cnt, 0);
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Basic packet with timing checks
        push_pkt(64'h0123_4567_89AB_CDEF, 8'hA5);
        stb_t.delete();
        check("busy_before_capture", busy, 0);
        pulse(64'h0123_4567_89AB_CDEF);
        check("busy_after_capture", busy, 1);
        wait_strobes(10);
        check("basic_strobe_count", stb_t.size(), 10);
        for (int i = 1; i < stb_t.size(); i++)
            check("basic_spacing", stb_t[i] - stb_t[i-1], GAP + 1);
        wait_idle(n);
        check("busy_fall_delay", n, GAP);
        check("basic_queue_empty", exp_q.size(), 0);

        // Backpressure before the third byte
        push_pkt(64'h0123_4567_89AB_CDEF, 8'hA5);
        stb_t.delete();
        pulse(64'h0123_4567_89AB_CDEF);
        wait_strobes(2);
        tx_ready = 1'b0;
        repeat (50) tick();
        tx_ready = 1'b1;
        t = cyc;
        wait_strobes(8);
        check("bp_strobe_count", stb_t.size(), 10);
        check("bp_third_byte_cycle", stb_t[2], t + 1);
        wait_idle(n);
        check("bp_queue_empty", exp_q.size(), 0);

        // Drops while busy
        push_pkt(64'h1, 8'hA4);
        pulse(64'h1);
        wait_strobes(2);
        pulse(64'hDEAD);
        wait_strobes(1);
        pulse(64'hBEEF);
        pulse(64'hCAFE);
        wait_strobes(7);
        wait_idle(n);
        check("drop_count_3", drop_cnt, 3);
        repeat (30) tick();
        check("drop_queue_empty", exp_q.size(), 0);

        // Saturation while stalled in the header state
        tx_ready = 1'b0;
        pulse(64'h55);
        repeat (300) pulse(64'h77);
        check("drop_saturated", drop_cnt, 255);
        repeat (5) pulse(64'h77);
        check("drop_holds", drop_cnt, 255);
        check("stalled_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("sat_reset_drop", drop_cnt, 0);
        check("sat_reset_busy", busy, 0);
        tick();
        rstn = 1'b1;
        tx_ready = 1'b1;
        tick();

        // Reset mid-packet
        push_pkt(64'h0123_4567_89AB_CDEF, 8'hA5);
        pulse(64'h0123_4567_89AB_CDEF);
        wait_strobes(4);
        tick();
        tick();
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_txvalid", com_txvalid, 0);
        check("midrst_txdata", com_txdata, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop_cnt, 0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (40) tick();
        check("midrst_idle_busy", busy, 0);

        push_pkt(64'hDEAD_BEEF_0011_2233, 8'h87);
        pulse(64'hDEAD_BEEF_0011_2233);
        wait_strobes(10);
        // Result in the final gap cycle is dropped
        repeat (GAP - 1) tick();
        res_data  = 64'h1234;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("gap_end_busy_low", busy, 0);
        check("gap_end_drop", drop_cnt, 1);

        // Back-to-back: one cycle after busy falls
        tick();
        push_pkt(64'hFFFF_FFFF_FFFF_FFFF, 8'hA5);
        pulse(64'hFFFF_FFFF_FFFF_FFFF);
        check("b2b_busy", busy, 1);
        wait_strobes(10);
        wait_idle(n);
        check("b2b_drop_unchanged", drop_cnt, 1);
        repeat (30) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_packetizer.md
Name: result_packetizer

Overview:
- Transmit-side framer for the host link. On each `res_valid` pulse it captures a `DATA_W`-bit result word (MSE accumulator from the data collector), then emits a fixed-format packet over the byte interface feeding the UART transmitter.
- Packet format: header byte, data bytes MSB-first, XOR checksum byte.
- Sits between the data collector and the UART transmitter. It is the sending counterpart of the host command receiver path.

Parameters:
- DATA_W, 64, result word width; must be a multiple of 8.
- HEADER, 8'hA5, first byte of every packet.
- GAP_CYC, 16, minimum idle cycles between consecutive bytes after `tx_ready` is seen.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- res_valid  in  1  single-cycle pulse; `res_data` is valid in this cycle.
- res_data  in  DATA_W  result word to send.
- tx_ready  in  1  UART transmitter idle and able to accept a byte.
- com_txvalid  out  1  single-cycle byte strobe to the UART transmitter.
- com_txdata  out  8  byte to transmit; valid when `com_txvalid` is high.
- busy  out  1  high from capture until the checksum byte is issued and the gap expires.
- drop_cnt  out  8  saturating count of results dropped while busy.

Behaviour:
- Reset (rstn=0, async), all outputs:
  - `com_txvalid`=0, `com_txdata`=8'h00, `busy`=0, `drop_cnt`=0.
  - FSM enters IDLE; shadow register and checksum clear.
  - Reset mid-packet aborts the packet; no further bytes are sent after reset releases.
- Byte count: NB = DATA_W/8 data bytes. Total packet = NB+2 bytes.
- FSM states: IDLE, HDR, DATA, CSUM, GAP.
- IDLE:
  - On `res_valid`=1: latch `res_data` into shadow, checksum <= HEADER, byte index <= NB-1, `busy`<=1, go to HDR.
  - `busy` is registered and rises the cycle after `res_valid`.
- HDR, DATA, CSUM: a byte is issued in the first cycle the state is entered with `tx_ready`=1.
  - Issue means `com_txvalid`=1 for exactly one cycle, with `com_txdata` registered on the same edge.
  - After each issue go to GAP. GAP counts GAP_CYC cycles, then returns to the next byte state.
  - While `tx_ready`=0, hold state with `com_txvalid`=0; no timeout.
- HDR issues HEADER.
- DATA issues shadow[8*idx+7 : 8*idx], starting at idx=NB-1 (MSB byte first).
  - Checksum ^= that byte; idx decrements.
  - After idx=0 is issued, the next byte state is CSUM.
- CSUM issues checksum = HEADER ^ all data bytes.
  - After its GAP, return to IDLE and drop `busy` to 0.
- Byte rate: minimum spacing between `com_txvalid` pulses is GAP_CYC+1 cycles, even if `tx_ready` stays high.
- Result arriving while busy:
  - `res_valid` in any state other than IDLE is ignored; shadow is unchanged.
  - `drop_cnt` increments and saturates at 255.
  - `res_valid` in the same cycle that GAP→IDLE completes is also dropped. It is accepted only when the FSM is already in IDLE.
- Simultaneous reset and `res_valid`: reset wins.
- `com_txdata` holds its last value between strobes; consumers sample only on `com_txvalid`.

Test Plan:
- Basic packet:
  - Stimulus: reset, `tx_ready`=1, pulse `res_valid` with `res_data`=64'h0123_4567_89AB_CDEF.
  - Required: 10 strobes with bytes A5,01,23,45,67,89,AB,CD,EF,(A5^01^23^45^67^89^AB^CD^EF = 8'hA5).
  - Required: strobes exactly GAP_CYC+1 cycles apart; `busy` falls GAP_CYC cycles after the last strobe.
- Backpressure:
  - Stimulus: as basic, with `tx_ready` held low for 50 cycles before the 3rd byte.
  - Required: no strobe during the stall; the byte sequence is identical; the 3rd byte issues the first cycle `tx_ready` returns high (after its gap).
- Drop while busy:
  - Stimulus: pulse `res_valid` (data=64'h1) then 3 more pulses mid-packet.
  - Required: only the first packet is sent (data bytes 00×7, 01; checksum A4); `drop_cnt`=3.
- Saturation:
  - Stimulus: 300 `res_valid` pulses while `tx_ready`=0 after the first capture.
  - Required: `drop_cnt`=255 and holds.
- Reset mid-packet:
  - Stimulus: assert `rstn`=0 after the 4th strobe, release, keep `tx_ready`=1.
  - Required: outputs return to reset values immediately; no strobes until a new `res_valid`; the next packet is complete and correct.
- Back-to-back:
  - Stimulus: second `res_valid` (data=all ones) 1 cycle after `busy` falls.
  - Required: accepted; packet A5, FF×8, A5; `drop_cnt` unchanged.
